// File: rtl/pc_redirect_if.sv
// Branch-decision interface between the EX stage (master) and the PC redirect unit (slave).
// The resolved_cnt/taken_cnt signals exist only when BRANCH_STATS_EN is defined.
interface pc_redirect_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            branch_valid;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush_if;
    logic            flush_id;
    logic            redirect_busy;
`ifdef BRANCH_STATS_EN
    logic [15:0]     resolved_cnt;
    logic [15:0]     taken_cnt;

    modport master (
        output stall, branch_valid, branch_taken, branch_target,
        input  pc, fetch_valid, flush_if, flush_id, redirect_busy,
        input  resolved_cnt, taken_cnt
    );
    modport slave (
        input  stall, branch_valid, branch_taken, branch_target,
        output pc, fetch_valid, flush_if, flush_id, redirect_busy,
        output resolved_cnt, taken_cnt
    );
`else
    modport master (
        output stall, branch_valid, branch_taken, branch_target,
        input  pc, fetch_valid, flush_if, flush_id, redirect_busy
    );
    modport slave (
        input  stall, branch_valid, branch_taken, branch_target,
        output pc, fetch_valid, flush_if, flush_id, redirect_busy
    );
`endif
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter owner with static predict-not-taken and a flush FSM for taken branches.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_redirect_unit #(
    parameter int PC_W         = 8,
    parameter int RESET_PC     = 0,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         reset_n,
    pc_redirect_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
    localparam logic [1:0]      CNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t          state_r;
    logic [1:0]      cnt_r;
    logic [PC_W-1:0] pc_r;
    logic            fetch_valid_r;
    logic            flush_if_r;
    logic            flush_id_r;
    logic            busy_r;
    logic            redirect_s;
    logic [PC_W-1:0] pc_seq_s;

    // Redirect decision and sequential next PC; branches seen in FLUSH are wrong-path.
    always_comb begin
        redirect_s = 1'b0;
        pc_seq_s   = pc_r;
        if (state_r == ST_IDLE) begin
            redirect_s = bus.branch_valid & bus.branch_taken;
        end else begin
            redirect_s = 1'b0;
        end
        if (bus.stall) begin
            pc_seq_s = pc_r;
        end else begin
            pc_seq_s = pc_r + PC_STEP;
        end
    end

    // Flush FSM with PC and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 2'd0;
            pc_r          <= PC_RST;
            fetch_valid_r <= 1'b1;
            flush_if_r    <= 1'b0;
            flush_id_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_s) begin
                        state_r       <= ST_FLUSH;
                        cnt_r         <= CNT_INIT;
                        pc_r          <= bus.branch_target;
                        fetch_valid_r <= 1'b0;
                        flush_if_r    <= 1'b1;
                        flush_id_r    <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        pc_r <= pc_seq_s;
                    end
                end
                ST_FLUSH: begin
                    pc_r <= pc_seq_s;
                    if (cnt_r == 2'd0) begin
                        state_r       <= ST_IDLE;
                        fetch_valid_r <= 1'b1;
                        flush_if_r    <= 1'b0;
                        flush_id_r    <= 1'b0;
                        busy_r        <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= 2'd0;
                    fetch_valid_r <= 1'b1;
                    flush_if_r    <= 1'b0;
                    flush_id_r    <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = pc_r;
    assign bus.fetch_valid   = fetch_valid_r;
    assign bus.flush_if      = flush_if_r;
    assign bus.flush_id      = flush_id_r;
    assign bus.redirect_busy = busy_r;

`ifdef BRANCH_STATS_EN
    logic [15:0] resolved_cnt_r;
    logic [15:0] taken_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Saturating counters of branches resolved and taken while IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resolved_cnt_r <= 16'd0;
            taken_cnt_r    <= 16'd0;
        end else begin
            if ((state_r == ST_IDLE) && bus.branch_valid) begin
                resolved_cnt_r <= sat_inc(resolved_cnt_r);
            end
            if (redirect_s) begin
                taken_cnt_r <= sat_inc(taken_cnt_r);
            end
        end
    end

    assign bus.resolved_cnt = resolved_cnt_r;
    assign bus.taken_cnt    = taken_cnt_r;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pc_redirect_unit;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    // reference model state
    logic [7:0] m_pc = 8'h00;
    int         m_flush_left = 0;
    int         m_resolved = 0;
    int         m_taken = 0;

    pc_redirect_if #(.PC_W(8)) bus ();

    pc_redirect_unit #(
        .PC_W(8), .RESET_PC(0), .PC_INC(1), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic fl;
        fl = (m_flush_left > 0);
        chk("pc", {24'd0, bus.pc}, {24'd0, m_pc});
        chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, ~fl});
        chk("flush_if", {31'd0, bus.flush_if}, {31'd0, fl});
        chk("flush_id", {31'd0, bus.flush_id}, {31'd0, fl});
        chk("redirect_busy", {31'd0, bus.redirect_busy}, {31'd0, fl});
`ifdef BRANCH_STATS_EN
        chk("resolved_cnt", {16'd0, bus.resolved_cnt}, m_resolved);
        chk("taken_cnt", {16'd0, bus.taken_cnt}, m_taken);
`endif
    endtask

    // One clock with the given inputs; model advances, then outputs are checked.
    task automatic step(input logic rst, input logic st, input logic bv, input logic bt,
                        input logic [7:0] tgt);
        reset_n           = ~rst;
        bus.stall         = st;
        bus.branch_valid  = bv;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        @(posedge clk);
        if (rst) begin
            m_pc = 8'h00;
            m_flush_left = 0;
            m_resolved = 0;
            m_taken = 0;
        end else begin
            if (m_flush_left == 0 && bv && m_resolved < 65535) m_resolved++;
            if (m_flush_left == 0 && bv && bt) begin
                m_pc = tgt;
                m_flush_left = FC;
                if (m_taken < 65535) m_taken++;
            end else begin
                if (!st) m_pc = m_pc + 8'd1;
                if (m_flush_left > 0) m_flush_left--;
            end
        end
        #1;
        if (!rst) check_model();
    endtask

    task automatic goto_pc(input logic [7:0] a);
        step(1'b0, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus.stall = 1'b0; bus.branch_valid = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 8'h00;

        // 1: reset then sequential fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        chk("t1_reset_pc", {24'd0, bus.pc}, 32'h00);
        chk("t1_reset_flush", {31'd0, bus.flush_if}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t1_pc1", {24'd0, bus.pc}, 32'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t1_pc2", {24'd0, bus.pc}, 32'h02);

        // 2: taken redirect and flush window
        goto_pc(8'h10);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        chk("t2_target", {24'd0, bus.pc}, 32'h40);
        chk("t2_flush_a", {31'd0, bus.flush_if}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_pc41", {24'd0, bus.pc}, 32'h41);
        chk("t2_flush_b", {31'd0, bus.flush_id}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_busy_clear", {31'd0, bus.redirect_busy}, 32'h0);

        // 3: not-taken and taken-without-valid
        goto_pc(8'h20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        chk("t3_nottaken", {24'd0, bus.pc}, 32'h21);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        chk("t3_novalid", {24'd0, bus.pc}, 32'h22);

        // 4: wrap and redirect beating stall; target == pc+1 still flushes
        goto_pc(8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4_wrap", {24'd0, bus.pc}, 32'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h08);
        chk("t4_stall_redirect", {24'd0, bus.pc}, 32'h08);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, bus.pc + 8'd1);
        chk("t4_seq_target_flush", {31'd0, bus.flush_if}, 32'h1);

        // 5: branch during flush ignored, reset mid-flush
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h30);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h90);
        chk("t5_ignored", {24'd0, bus.pc}, 32'h31);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t5_no_new_flush", {31'd0, bus.flush_if}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h50);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        chk("t5_rst_pc", {24'd0, bus.pc}, 32'h00);
        chk("t5_rst_flush", {31'd0, bus.flush_if}, 32'h0);

`ifdef BRANCH_STATS_EN
        // 6: statistics
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h60);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h70);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("t6_resolved", {16'd0, bus.resolved_cnt}, 32'd2);
        chk("t6_taken", {16'd0, bus.taken_cnt}, 32'd1);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
